pwrgd_rst_sequencer: RTL and testbench
======================================

PWRGD_RST_SEQUENCER -- requirements
Module: pwrgd_rst_sequencer

Interface
REQ-001 SHALL have parameter DLY_W, 16, width of the delay config inputs and the delay counter.
REQ-002 SHALL have parameter WD_CYCLES, 100000, per-stage ack watchdog limit in tb_clk cycles (1 ms at 100 MHz).
REQ-003 SHALL have port tb_clk  in  1  single clock; all state on posedge.
REQ-004 SHALL have port tb_rst_b  in  1  asynchronous, active-low reset.
REQ-005 SHALL have port start  in  1  begin sequence; sampled in IDLE only.
REQ-006 SHALL have port abort  in  1  synchronous return to IDLE with all resets re-asserted.
REQ-007 SHALL have port pwrgd_dly  in  DLY_W  cycles from start to powergood release.
REQ-008 SHALL have port stg_dly  in  DLY_W  cycles before each domain release.
REQ-009 SHALL have port dom_ack  in  3  per-domain ready; bit0 cclk, bit1 clk, bit2 mclk.
REQ-010 SHALL have port lan_powergood_rst_b  out  1  powergood reset, active-low.
REQ-011 SHALL have port dom_rst_b  out  3  domain resets, active-low; same bit order as dom_ack.
REQ-012 SHALL have port busy  out  1  high in PWRGD, STG_DLY and STG_ACK.
REQ-013 SHALL have port done  out  1  level, high in DONE.
REQ-014 SHALL have port wd_expired  out  1  high in FAIL.
REQ-015 SHALL have port fail_stage  out  2  stage index that timed out; valid while wd_expired=1.

Function
REQ-016 SHALL implement states IDLE, PWRGD, STG_DLY, STG_ACK, DONE and FAIL, plus a 2-bit stage index idx, a DLY_W-bit delay counter and a watchdog counter.
REQ-017 SHALL register all outputs; no combinational path from any input to any output.
REQ-018 In IDLE, a sampled start SHALL select PWRGD and load the counter with pwrgd_dly (defined as edge 0).
REQ-019 In PWRGD and STG_DLY, the counter SHALL decrement each edge while nonzero; the state SHALL exit on the edge at which the counter equals 0.
REQ-020 On PWRGD exit, lan_powergood_rst_b SHALL go to 1, idx SHALL go to 0, the state SHALL be STG_DLY and the counter SHALL load stg_dly; this is edge P+1 for pwrgd_dly=P.
REQ-021 On STG_DLY exit, dom_rst_b[idx] SHALL go to 1, the state SHALL be STG_ACK and the watchdog SHALL clear.
REQ-022 In STG_ACK with dom_ack[idx]=1 sampled, the state SHALL go to DONE if idx=2; otherwise idx SHALL increment, the state SHALL go to STG_DLY and the counter SHALL load stg_dly.
REQ-023 With acks already high, dom_rst_b[k] SHALL rise at edge P+S+2+k*(S+2) and done SHALL rise at edge P+3S+7 (S=stg_dly).
REQ-024 dom_ack bits other than idx, and any ack outside STG_ACK, SHALL be ignored.
REQ-025 pwrgd_dly and stg_dly SHALL be sampled only at counter load; a change mid-count SHALL have no effect.
REQ-026 Delay 0 SHALL cause exit on the edge after entry; no underflow or wrap is permitted.
REQ-027 In STG_ACK, the watchdog SHALL count each edge without ack; at WD_CYCLES counts the state SHALL go to FAIL.
REQ-028 Entering FAIL SHALL set fail_stage=idx and wd_expired=1 and drive all resets to 0 on the same edge.
REQ-029 If ack and watchdog expiry occur on the same edge, the ack SHALL win.
REQ-030 DONE and FAIL SHALL hold, and start SHALL be ignored, until abort.
REQ-031 start while busy SHALL be ignored.
REQ-032 abort from any state SHALL give IDLE next edge: all resets 0, done=0, wd_expired=0, idx=0.
REQ-033 abort SHALL take priority over start, ack and watchdog expiry sampled on the same edge.

Reset
REQ-034 tb_rst_b=0 SHALL immediately and asynchronously force IDLE, counters=0, idx=0, lan_powergood_rst_b=0, dom_rst_b=3'b000, busy=0, done=0, wd_expired=0 and fail_stage=0.
REQ-035 Reset mid-sequence SHALL discard progress; after deassertion the block SHALL remain in IDLE until a new start.

Verification
REQ-036 pwrgd_dly=4, stg_dly=2, dom_ack=3'b111, start at edge 0 -> pwrgd rises edge 5; dom_rst_b bits rise edges 8, 12, 16; done rises edge 17; busy falls edge 17.
REQ-037 WD_CYCLES=16, dom_ack[1] stuck at 0 -> FAIL 16 edges after dom_rst_b[1] rises; fail_stage=1, wd_expired=1, all resets 0; abort -> IDLE, wd_expired=0.
REQ-038 abort pulse during stage-1 STG_DLY -> next edge all resets 0, busy=0; a subsequent start replays the full sequence with identical timing.
REQ-039 pwrgd_dly=0, stg_dly=0, acks high -> pwrgd at edge 1; dom resets at edges 2, 4, 6; done at edge 7.
REQ-040 dom_ack=3'b110 early, and start re-pulsed while busy -> stage 0 waits for bit0; the second start has no effect on timing.
REQ-041 tb_rst_b asserted mid-STG_ACK (no clock edge) -> all outputs take reset values immediately; the block stays in IDLE after release.

Source files
------------

// File: rtl/pwrgd_rst_sequencer.sv
// Power-good and three-domain reset release sequencer.
// Releases each domain in turn, waits for its ack, and traps in FAIL on watchdog expiry.
module pwrgd_rst_sequencer #(
   parameter int DLY_W     = 16,
   parameter int WD_CYCLES = 100000
) (
   input  logic             tb_clk,
   input  logic             tb_rst_b,
   input  logic             start,
   input  logic             abort,
   input  logic [DLY_W-1:0] pwrgd_dly,
   input  logic [DLY_W-1:0] stg_dly,
   input  logic [2:0]       dom_ack,
   output logic             lan_powergood_rst_b,
   output logic [2:0]       dom_rst_b,
   output logic             busy,
   output logic             done,
   output logic             wd_expired,
   output logic [1:0]       fail_stage
);

   localparam int WD_W = $clog2(WD_CYCLES + 1);
   localparam logic [WD_W-1:0] WD_LAST = WD_W'(WD_CYCLES - 1);

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      PWRGD   = 3'd1,
      STG_DLY = 3'd2,
      STG_ACK = 3'd3,
      DONE    = 3'd4,
      FAIL    = 3'd5
   } state_t;

   state_t           state_q;
   logic [1:0]       idx_q;
   logic [DLY_W-1:0] cnt_q;
   logic [WD_W-1:0]  wd_q;
   logic             pg_q;
   logic [2:0]       dom_q;
   logic             busy_q;
   logic             done_q;
   logic             wdx_q;
   logic [1:0]       fstg_q;

   always_ff @(posedge tb_clk or negedge tb_rst_b) begin
      if (!tb_rst_b) begin
         state_q <= IDLE;
         idx_q   <= 2'd0;
         cnt_q   <= '0;
         wd_q    <= '0;
         pg_q    <= 1'b0;
         dom_q   <= 3'b000;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         wdx_q   <= 1'b0;
         fstg_q  <= 2'd0;
      end else if (abort) begin
         state_q <= IDLE;
         idx_q   <= 2'd0;
         cnt_q   <= '0;
         wd_q    <= '0;
         pg_q    <= 1'b0;
         dom_q   <= 3'b000;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         wdx_q   <= 1'b0;
      end else begin
         unique case (state_q)
            IDLE: begin
               if (start) begin
                  state_q <= PWRGD;
                  cnt_q   <= pwrgd_dly;
                  busy_q  <= 1'b1;
               end
            end
            PWRGD: begin
               if (cnt_q == '0) begin
                  state_q <= STG_DLY;
                  pg_q    <= 1'b1;
                  idx_q   <= 2'd0;
                  cnt_q   <= stg_dly;
               end else begin
                  cnt_q <= cnt_q - DLY_W'(1);
               end
            end
            STG_DLY: begin
               if (cnt_q == '0) begin
                  state_q      <= STG_ACK;
                  dom_q[idx_q] <= 1'b1;
                  wd_q         <= '0;
               end else begin
                  cnt_q <= cnt_q - DLY_W'(1);
               end
            end
            STG_ACK: begin
               // An ack on the expiry edge still counts as success.
               if (dom_ack[idx_q]) begin
                  if (idx_q == 2'd2) begin
                     state_q <= DONE;
                     busy_q  <= 1'b0;
                     done_q  <= 1'b1;
                  end else begin
                     state_q <= STG_DLY;
                     idx_q   <= idx_q + 2'd1;
                     cnt_q   <= stg_dly;
                  end
               end else if (wd_q == WD_LAST) begin
                  state_q <= FAIL;
                  fstg_q  <= idx_q;
                  wdx_q   <= 1'b1;
                  pg_q    <= 1'b0;
                  dom_q   <= 3'b000;
                  busy_q  <= 1'b0;
               end else begin
                  wd_q <= wd_q + WD_W'(1);
               end
            end
            DONE, FAIL: begin
            end
            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign lan_powergood_rst_b = pg_q;
   assign dom_rst_b           = dom_q;
   assign busy                = busy_q;
   assign done                = done_q;
   assign wd_expired          = wdx_q;
   assign fail_stage          = fstg_q;

endmodule

// File: tb/tb_pwrgd_rst_sequencer.sv
// Bench for pwrgd_rst_sequencer: directed and random sequences vs an edge-time model.
// Expected release/done/fail edges are derived arithmetically from the delays and ack times.
module tb_pwrgd_rst_sequencer;

   localparam int WD  = 16;
   localparam int INF = 1000000;

   logic        tb_clk = 1'b0;
   logic        tb_rst_b;
   logic        start;
   logic        abort;
   logic [15:0] pwrgd_dly;
   logic [15:0] stg_dly;
   logic [2:0]  dom_ack;
   logic        lan_powergood_rst_b;
   logic [2:0]  dom_rst_b;
   logic        busy;
   logic        done;
   logic        wd_expired;
   logic [1:0]  fail_stage;

   int vecs = 0;
   int errs = 0;

   int mp, ms;
   int ak[3];
   int rel[3];
   int done_e, fail_e, fail_k;

   pwrgd_rst_sequencer #(.DLY_W(16), .WD_CYCLES(WD)) dut (
      .tb_clk(tb_clk), .tb_rst_b(tb_rst_b), .start(start), .abort(abort),
      .pwrgd_dly(pwrgd_dly), .stg_dly(stg_dly), .dom_ack(dom_ack),
      .lan_powergood_rst_b(lan_powergood_rst_b), .dom_rst_b(dom_rst_b),
      .busy(busy), .done(done), .wd_expired(wd_expired), .fail_stage(fail_stage)
   );

   always #5 tb_clk = ~tb_clk;

   function automatic logic [6:0] obs();
      return {lan_powergood_rst_b, dom_rst_b, busy, done, wd_expired};
   endfunction

   task automatic chk(input string tag, input int n,
                      input logic [6:0] got, input logic [6:0] exp);
      vecs++;
      assert (got === exp) else begin
         errs++;
         $error("FAIL %s edge=%0d observed=%b expected=%b", tag, n, got, exp);
      end
   endtask

   task automatic chk_fs(input int n, input logic [1:0] exp);
      vecs++;
      assert (fail_stage === exp) else begin
         errs++;
         $error("FAIL fail_stage edge=%0d observed=%0d expected=%0d",
                n, fail_stage, exp);
      end
   endtask

   // Release edge of stage k, first edge its ack is seen, then next stage or done/fail.
   task automatic plan();
      int t;
      done_e = INF; fail_e = INF; fail_k = 0;
      rel[0] = mp + ms + 2; rel[1] = INF; rel[2] = INF;
      for (int k = 0; k < 3; k++) begin
         t = (ak[k] > rel[k] + 1) ? ak[k] : rel[k] + 1;
         if (t > rel[k] + WD) begin
            fail_e = rel[k] + WD;
            fail_k = k;
            break;
         end
         if (k < 2) rel[k+1] = t + ms + 1;
         else done_e = t;
      end
   endtask

   function automatic logic [6:0] model(input int n);
      logic [2:0] d;
      if (n >= fail_e) return 7'b0000001;
      for (int k = 0; k < 3; k++) d[k] = (n >= rel[k]);
      return {n >= mp + 1, d, n < done_e, n >= done_e, 1'b0};
   endfunction

   function automatic logic [2:0] ackv(input int n);
      return {n >= ak[2], n >= ak[1], n >= ak[0]};
   endfunction

   task automatic run(input int p, input int s, input int a0, input int a1,
                      input int a2, input int ab, input int rs, input bit noise);
      int last;
      mp = p; ms = s; ak[0] = a0; ak[1] = a1; ak[2] = a2;
      plan();
      last = ((fail_e < done_e) ? fail_e : done_e) + 3;
      if (ab >= 0) last = ab;
      if (rs >= 0) last = rs;
      pwrgd_dly = 16'(p); stg_dly = 16'(s); abort = 1'b0; start = 1'b1;
      dom_ack = ackv(0);
      @(negedge tb_clk);
      for (int n = 0; n <= last; n++) begin
         if (n == ab) begin
            chk("abort", n, obs(), 7'b0);
         end else begin
            chk("seq", n, obs(), model(n));
            if (n >= fail_e) chk_fs(n, 2'(fail_k));
         end
         if (n == last) break;
         start     = noise ? 1'($urandom_range(0, 1)) : 1'b0;
         pwrgd_dly = noise ? 16'($urandom_range(0, 50)) : 16'(p);
         stg_dly   = (noise && n + 1 <= p) ? 16'($urandom_range(0, 50)) : 16'(s);
         dom_ack   = ackv(n + 1);
         abort     = (n + 1 == ab);
         if (n + 1 == ab && noise) start = 1'b1;
         @(negedge tb_clk);
      end
      if (rs >= 0) begin
         #2 tb_rst_b = 1'b0;
         #1 chk("async_rst", rs, obs(), 7'b0);
         chk_fs(rs, 2'd0);
         @(negedge tb_clk);
         start = 1'b0; abort = 1'b0;
         tb_rst_b = 1'b1;
         for (int i = 0; i < 3; i++) begin
            @(negedge tb_clk);
            chk("post_rst_idle", i, obs(), 7'b0);
         end
         return;
      end
      start = noise ? 1'b1 : 1'b0;
      if (ab < 0) begin
         abort = 1'b1;
         @(negedge tb_clk);
         chk("abort_end", last + 1, obs(), 7'b0);
      end
      abort = 1'b0; start = 1'b0;
      @(negedge tb_clk);
      chk("idle", 0, obs(), 7'b0);
   endtask

   initial begin
      int r, a[3];
      tb_rst_b = 1'b0; start = 1'b0; abort = 1'b0;
      pwrgd_dly = '0; stg_dly = '0; dom_ack = '0;
      #3 chk("reset", 0, obs(), 7'b0);
      chk_fs(0, 2'd0);
      @(negedge tb_clk);
      tb_rst_b = 1'b1;
      @(negedge tb_clk);
      chk("reset_idle", 0, obs(), 7'b0);

      run(4, 2, 0, 0, 0, -1, -1, 1'b0);
      run(0, 0, 0, 0, 0, -1, -1, 1'b0);
      run(4, 2, 0, INF, 0, -1, -1, 1'b0);
      run(4, 2, 0, 0, 0, 10, -1, 1'b0);
      run(4, 2, 0, 0, 0, -1, -1, 1'b0);
      run(3, 1, 12, 0, 0, -1, -1, 1'b1);
      run(0, 0, 0, 20, 0, -1, -1, 1'b0);
      run(0, 0, 0, 21, 0, -1, -1, 1'b0);
      run(0, 0, 0, 0, INF, -1, -1, 1'b1);
      run(2, 1, 0, INF, 0, -1, 11, 1'b0);

      for (int i = 0; i < 30; i++) begin
         for (int k = 0; k < 3; k++) begin
            r = $urandom_range(0, 9);
            a[k] = (r == 0) ? INF : $urandom_range(0, 40);
         end
         run($urandom_range(0, 6), $urandom_range(0, 4), a[0], a[1], a[2],
             -1, -1, 1'b1);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end

endmodule
